// File: rtl/demux1_4_buf.sv
// demux1_4_buf: buffered 1-to-4 demultiplexer, one registered word per channel.
// Optional round-robin steering is enabled by defining DEMUX4_RR_EN.
module demux1_4_buf #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             va,
   output logic             vb,
   output logic             vc,
   output logic             vd,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   input  logic             rd
`ifdef DEMUX4_RR_EN
   ,
   input  logic             rr
`endif
);

   logic [WIDTH-1:0] data_r [4];
   logic [3:0]       valid_r;
   logic [3:0]       rdy_s;
   logic [1:0]       sel_s;
   logic             accept_s;

   assign rdy_s = {rd, rc, rb, ra};

`ifdef DEMUX4_RR_EN
   logic [1:0] ptr_r;

   // Steering source: pointer in round-robin mode, S otherwise.
   always_comb begin
      sel_s = S;
      if (rr) begin
         sel_s = ptr_r;
      end else begin
         sel_s = S;
      end
   end

   // Pointer advances only on accepts taken while round-robin is requested.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= 2'b00;
      end else if (accept_s && rr) begin
         ptr_r <= ptr_r + 2'd1;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   assign sel_s = S;
`endif

   // Selected channel takes a word when empty or draining in the same cycle.
   always_comb begin
      in_ready = ~valid_r[sel_s] | rdy_s[sel_s];
      accept_s = in_valid & in_ready;
   end

   // Per-channel load/drain; a refill wins over the drain so no bubble appears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            data_r[k] <= {WIDTH{1'b0}};
         end
         valid_r <= 4'b0000;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (accept_s && (sel_s == 2'(k))) begin
               data_r[k]  <= in;
               valid_r[k] <= 1'b1;
            end else if (valid_r[k] && rdy_s[k]) begin
               valid_r[k] <= 1'b0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
      end
   end

   assign a  = data_r[0];
   assign b  = data_r[1];
   assign c  = data_r[2];
   assign d  = data_r[3];
   assign va = valid_r[0];
   assign vb = valid_r[1];
   assign vc = valid_r[2];
   assign vd = valid_r[3];

endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: directed plan plus randomized traffic
// compared every cycle against a channel-array model.
`timescale 1ns/1ps
module tb_demux1_4_buf;
   localparam int W = 8;
`ifdef DEMUX4_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [W-1:0] in = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   S = 2'b00;
   logic [W-1:0] a, b, c, d;
   logic         va, vb, vc, vd;
   logic         ra = 1'b1, rb = 1'b1, rc = 1'b1, rd = 1'b1;
   logic         rr = 1'b0;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;

   demux1_4_buf #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .S(S), .a(a), .b(b), .c(c), .d(d), .va(va), .vb(vb), .vc(vc), .vd(vd),
      .ra(ra), .rb(rb), .rc(rc), .rd(rd)
`ifdef DEMUX4_RR_EN
      , .rr(rr)
`endif
   );

   always #5 clk = ~clk;

   // Reference: what each channel holds, plus the round-robin pointer.
   bit [W-1:0] m_d [4];
   bit         m_v [4];
   int         m_ptr = 0;

   function automatic bit r_of(int k);
      case (k)
         0: return ra;
         1: return rb;
         2: return rc;
         3: return rd;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [W-1:0] dout(int k);
      case (k)
         0: return a;
         1: return b;
         2: return c;
         3: return d;
         default: return 8'hxx;
      endcase
   endfunction

   function automatic logic vout(int k);
      case (k)
         0: return va;
         1: return vb;
         2: return vc;
         3: return vd;
         default: return 1'bx;
      endcase
   endfunction

   function automatic int cur_sel();
      return (RR_EN && rr) ? m_ptr : int'(S);
   endfunction

   function automatic bit exp_ready();
      int s;
      s = cur_sel();
      return !m_v[s] || r_of(s);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      int s;
      bit acc;
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            m_d[k] = 8'h00;
            m_v[k] = 1'b0;
         end
         m_ptr = 0;
      end else begin
         s = cur_sel();
         acc = in_valid && exp_ready();
         for (int k = 0; k < 4; k++) begin
            if (m_v[k] && r_of(k)) m_v[k] = 1'b0;
         end
         if (acc) begin
            m_d[s] = in;
            m_v[s] = 1'b1;
            if (RR_EN && rr) m_ptr = (m_ptr + 1) % 4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("model valid[%0d]", k), {31'd0, vout(k)}, {31'd0, m_v[k]});
            chk($sformatf("model data[%0d]", k), {24'd0, dout(k)}, {24'd0, m_d[k]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] data, input logic [1:0] sel);
      in = data;
      S = sel;
      in_valid = 1'b1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #2;
      for (int k = 0; k < 4; k++) begin
         chk("reset data", {24'd0, dout(k)}, 32'h0);
         chk("reset valid", {31'd0, vout(k)}, 32'h0);
      end
      chk("reset in_ready", {31'd0, in_ready}, 32'h1);
      tick();
      reset_n = 1'b1;
      cmp_en = 1'b1;

      // Steer one word to each channel; each is visible for exactly one cycle.
      send(8'h11, 2'd0); tick();
      chk("steer a", {24'd0, a}, 32'h11); chk("steer va", {31'd0, va}, 32'h1);
      send(8'h22, 2'd1); tick();
      chk("steer b", {24'd0, b}, 32'h22); chk("steer va drop", {31'd0, va}, 32'h0);
      send(8'h33, 2'd2); tick();
      chk("steer c", {24'd0, c}, 32'h33); chk("steer vb drop", {31'd0, vb}, 32'h0);
      send(8'h44, 2'd3); tick();
      chk("steer d", {24'd0, d}, 32'h44); chk("steer vc drop", {31'd0, vc}, 32'h0);
      in_valid = 1'b0; tick();
      chk("steer vd drop", {31'd0, vd}, 32'h0); chk("steer d kept", {24'd0, d}, 32'h44);

      // Backpressure on a blocks only a.
      ra = 1'b0; send(8'hA5, 2'd0); tick();
      chk("bp a", {24'd0, a}, 32'hA5); chk("bp va", {31'd0, va}, 32'h1);
      send(8'h77, 2'd0); #1;
      chk("bp ready low", {31'd0, in_ready}, 32'h0);
      tick();
      chk("bp a held", {24'd0, a}, 32'hA5); chk("bp va held", {31'd0, va}, 32'h1);
      send(8'h5A, 2'd1); #1;
      chk("bp other ready", {31'd0, in_ready}, 32'h1);
      tick();
      chk("bp b", {24'd0, b}, 32'h5A); chk("bp vb", {31'd0, vb}, 32'h1);

      // Drain and refill the same channel in one cycle.
      ra = 1'b1; send(8'h01, 2'd0); tick();
      chk("refill a 01", {24'd0, a}, 32'h01); chk("refill va", {31'd0, va}, 32'h1);
      send(8'h02, 2'd0); #1;
      chk("refill ready", {31'd0, in_ready}, 32'h1);
      tick();
      chk("refill a 02", {24'd0, a}, 32'h02); chk("refill va kept", {31'd0, va}, 32'h1);
      in_valid = 1'b0; tick();
      chk("refill va drop", {31'd0, va}, 32'h0);

      // Idle: ready consumers, nothing offered.
      repeat (10) tick();
      chk("idle valids", {28'd0, vd, vc, vb, va}, 32'h0);
      chk("idle data", {a, b, c, d}, 32'h025A3344);

      // Asynchronous reset while a and c hold words.
      ra = 1'b0; rc = 1'b0;
      send(8'hC1, 2'd0); tick();
      send(8'hC3, 2'd2); tick();
      in_valid = 1'b0;
      chk("pre-reset full", {28'd0, vd, vc, vb, va}, 32'h5);
      reset_n = 1'b0; #1;
      chk("async clr valids", {28'd0, vd, vc, vb, va}, 32'h0);
      chk("async clr data", {a, b, c, d}, 32'h0);
      tick();
      reset_n = 1'b1; ra = 1'b1; rc = 1'b1;

`ifdef DEMUX4_RR_EN
      rr = 1'b1; S = 2'd3;
      for (int i = 0; i < 6; i++) begin
         in = 8'h10 + 8'(i); in_valid = 1'b1; tick();
         chk($sformatf("rr data %0d", i), {24'd0, dout(i % 4)}, 32'h10 + i);
         chk($sformatf("rr valid %0d", i), {31'd0, vout(i % 4)}, 32'h1);
      end
      rr = 1'b0; send(8'h16, 2'd3); tick();
      chk("rr off d", {24'd0, d}, 32'h16);
      in_valid = 1'b0; tick();
`endif

      // Randomized traffic, occasional async reset pulses.
      for (int n = 0; n < 600; n++) begin
         in = 8'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         S = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 2) != 0);
         rb = ($urandom_range(0, 2) != 0);
         rc = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 2) != 0);
         rr = ($urandom_range(0, 1) != 0);
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         tick();
      end

      in_valid = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 demultiplexer: the distributing counterpart of the team's 4-to-1 selector. A word arriving on a single valid/ready input is steered by the 2-bit select `S` into one of four output channels `a`, `b`, `c`, `d`. Each channel holds one word in a register with its own valid/ready handshake. It sits between a single producer and four independent consumers in the datapath exercises, so one slow consumer stalls only its own channel.

## Interface
- `WIDTH`, default 1, data width of input and of every output channel.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  WIDTH  input word.
- `in_valid`  in  1  producer offers `in`.
- `in_ready`  out  1  block accepts `in` this cycle.
- `S`  in  2  channel select: 2'b00→a, 2'b01→b, 2'b10→c, 2'b11→d.
- `a`, `b`, `c`, `d`  out  WIDTH each  channel data registers.
- `va`, `vb`, `vc`, `vd`  out  1 each  channel holds a valid word.
- `ra`, `rb`, `rc`, `rd`  in  1 each  consumer takes the channel word this cycle.
- `rr`  in  1  round-robin mode request; present only with `DEMUX4_RR_EN`.

## Operation
- Per channel k: data register `k` and valid flag `vk`. Channel full = `vk`=1.
- Selected channel `sel` = `S`, or the round-robin pointer (see Configuration).
- `in_ready` = !v[sel] | r[sel], combinational from `S` / pointer, `v*` and `r*`. No dependency on `in_valid`.
- Accept = `in_valid` & `in_ready`. On accept: data[sel] <= `in`, v[sel] <= 1.
- Drain of channel k = `vk` & `rk`. On drain without refill: `vk` <= 0. Data register keeps its last value.
- Drain and refill of the same channel in one cycle: new word loaded, `vk` stays 1. No bubble.
- While `vk`=1 and `rk`=0, `k` and `vk` are held stable.
- `rk` while `vk`=0 is ignored.
- Unselected channels drain independently every cycle. A full selected channel blocks only the input, never the other channels.
- Reset (asynchronous, any time, including mid-transfer): `a`,`b`,`c`,`d` = 0; `va`..`vd` = 0; round-robin pointer = 2'b00. In-flight words are discarded.
- `in_ready` during reset follows its equation with all `v`=0, so it is 1. Producers must not count transfers while `reset_n`=0.

## Timing
- Latency 1 cycle: a word accepted at rising edge N shows on the channel with `vk`=1 immediately after edge N.
- Throughput: one word per cycle total. Per channel, one word per cycle when its consumer holds `rk`=1.
- Combinational paths:
  - `S`/`r*` → `in_ready`.
  - No path from `in` or `in_valid` to any output.
- Reset release is synchronous to `clk` by integration. The first accept is possible on the first edge with `reset_n`=1.

## Configuration
- `DEMUX4_RR_EN` defined:
  - Adds input `rr` and an internal 2-bit pointer `ptr`.
  - When `rr`=1, `sel` = `ptr` and `S` is ignored. `ptr` increments mod 4 (3→0) on each accept made while `rr`=1, and holds otherwise.
  - When `rr`=0, `sel` = `S` and `ptr` holds.
- `DEMUX4_RR_EN` undefined:
  - No `rr` port and no pointer.
  - `sel` = `S` always.

## Test plan
- Reset and steer (WIDTH=8, all `r*`=1): reset → all outputs 0 and `in_ready`=1. Then send 8'h11/S=0, 8'h22/S=1, 8'h33/S=2, 8'h44/S=3 on consecutive cycles → each channel shows its word with valid for exactly one cycle, one cycle after its accept.
- Backpressure: `ra`=0, send 8'hA5/S=0 → `va`=1, `a`=8'hA5. Next offer with S=0 → `in_ready`=0 and `a` stays 8'hA5. Same cycle S=1 with 8'h5A → accepted, `vb`=1.
- Drain+refill: `va`=1 holding 8'h01, `ra`=1, `in_valid`=1, S=0, `in`=8'h02 → `in_ready`=1. After the edge `a`=8'h02 and `va` stays 1.
- Idle consumers: ready asserted on empty channels, `in_valid`=0 for 10 cycles → all `v*` stay 0 and data registers unchanged.
- Reset mid-operation: `va`=`vc`=1 holding data, assert `reset_n`=0 between edges → outputs clear to 0 at once, without waiting for a clock edge.
- With `DEMUX4_RR_EN`: `rr`=1, S=3 held, all `r*`=1, send 8'h10..8'h15 → delivered to a,b,c,d,a,b in that order. `rr`=0 → steering follows S=3 again.
